// File: rtl/renkon_relu_bwd.sv
// ReLU backward stage: records a sign mask during the forward pass and replays it
// in order to gate the incoming gradient stream.
module renkon_relu_bwd #(
  parameter int DEPTH  = 4096,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     clear,
  input  logic                     fwd_en,
  input  logic signed [15:0]       fwd_pixel,
  input  logic                     bwd_en,
  input  logic signed [15:0]       grad_in,
  output logic signed [15:0]       grad_out,
  output logic                     grad_valid,
  output logic        [AWIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  // Datapath width shared with the rest of the renkon gradient path.
  localparam int DWIDTH = 16;

  logic              mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              mask_in;
  logic              mask_q;
  logic              push_ok;
  logic              pop_ok;
  logic              valid_d;
  logic              forced_zero_d;
  logic [DWIDTH-1:0] grad_d;

  // Strictly positive: sign bit clear and not all zeros.
  assign mask_in = !fwd_pixel[DWIDTH-1] && (|fwd_pixel);

  assign full    = (count == (AWIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = fwd_en && !full;
  assign pop_ok  = bwd_en && !empty;

  // Simple dual-port mask RAM; contents deliberately carry no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= mask_in;
    end
    if (pop_ok && !clear) begin
      mask_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      valid_d       <= 1'b0;
      forced_zero_d <= 1'b0;
      grad_d        <= '0;
      grad_valid    <= 1'b0;
      grad_out      <= '0;
    end else if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      valid_d       <= 1'b0;
      forced_zero_d <= 1'b0;
      grad_d        <= '0;
      grad_valid    <= 1'b0;
      grad_out      <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AWIDTH+1)'(push_ok) - (AWIDTH+1)'(pop_ok);
      if (fwd_en && full) begin
        overflow <= 1'b1;
      end
      if (bwd_en && empty) begin
        underflow <= 1'b1;
      end

      // Stage 1 lines up with the RAM read; an underflowed pop is forced to zero.
      valid_d       <= bwd_en;
      forced_zero_d <= bwd_en && empty;
      grad_d        <= grad_in;

      grad_valid <= valid_d;
      grad_out   <= (valid_d && mask_q && !forced_zero_d) ? grad_d : '0;
    end
  end

endmodule
